// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-192 key-schedule constants, word type, Rcon table
// and the RotWord helper.
package aes_pkg;

  localparam int unsigned AES192_NK = 6;
  localparam int unsigned AES192_NR = 12;
  localparam int unsigned AES192_NW = 52;

  typedef logic [31:0] aes_word_t;

  // Rcon[1..8] stored at index 0..7
  localparam logic [7:0] AES192_RCON [0:7] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
  };

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes192_keyex_step.sv
// aes192_keyex_step: one combinational AES-192 expansion step.
//   i_prev  : w(i-6)..w(i-1), w(i-6) in bits [191:160]
//   i_sbox  : SubWord(RotWord(w(i-1)))
//   i_rcon  : Rcon byte for this iteration
//   o_next  : w(i)..w(i+5), w(i) in bits [191:160]
module aes192_keyex_step
  import aes_pkg::*;
(
  input  logic [191:0] i_prev,
  input  logic [31:0]  i_sbox,
  input  logic [7:0]   i_rcon,
  output logic [191:0] o_next
);

  aes_word_t t;
  aes_word_t nw;

  always_comb begin
    o_next = '0;
    t      = i_sbox ^ {i_rcon, 24'h0};
    nw     = i_prev[191:160] ^ t;
    o_next[191:160] = nw;
    for (int unsigned j = 1; j < 6; j++) begin
      nw = i_prev[191 - 32*j -: 32] ^ nw;
      o_next[191 - 32*j -: 32] = nw;
    end
  end

endmodule

// File: rtl/aes192_keyex.sv
// aes192_keyex: iterative AES-192 key expansion, one 6-word group per clock.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_key, i_key_en    : cipher key and load/start strobe
//   o_keyex            : 52-word schedule, w0 at the MSBs
//   o_key_ok, o_busy   : schedule valid / expansion in progress
//   o_sbox_din         : RotWord(w(6n-1)) to the external S-box
//   i_sbox_dout        : combinational SubWord of o_sbox_din
// Optional macro AES192_KEYEX_ZEROIZE_EN adds i_zeroize (clears schedule,
// priority over i_key_en).
module aes192_keyex
  import aes_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [191:0]  i_key,
  input  logic          i_key_en,
`ifdef AES192_KEYEX_ZEROIZE_EN
  input  logic          i_zeroize,
`endif
  output logic [1663:0] o_keyex,
  output logic          o_key_ok,
  output logic          o_busy,
  output logic [31:0]   o_sbox_din,
  input  logic [31:0]   i_sbox_dout
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  aes_word_t    w [AES192_NW];
  logic [191:0] prev_grp;
  logic [191:0] next_grp;
  logic [7:0]   rcon;
  logic         zeroize;

`ifdef AES192_KEYEX_ZEROIZE_EN
  assign zeroize = i_zeroize;
`else
  assign zeroize = 1'b0;
`endif

  // Source group for iteration cnt; cnt=0 falls back to w0..w5 so the
  // S-box port tracks w5 while idle, and cnt=8 keeps w42..w47 when done.
  always_comb begin
    prev_grp = {w[0], w[1], w[2], w[3], w[4], w[5]};
    rcon     = AES192_RCON[0];
    for (int unsigned g = 1; g <= 8; g++) begin
      if (cnt == 4'(g)) begin
        for (int unsigned j = 0; j < 6; j++)
          prev_grp[191 - 32*j -: 32] = w[6*(g-1) + j];
        rcon = AES192_RCON[g-1];
      end
    end
  end

  assign o_sbox_din = rot_word(prev_grp[31:0]);

  aes192_keyex_step u_step (
    .i_prev (prev_grp),
    .i_sbox (i_sbox_dout),
    .i_rcon (rcon),
    .o_next (next_grp)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (zeroize)
      state_nxt = ST_IDLE;
    else if (i_key_en)
      state_nxt = ST_EXPAND;
    else if (state == ST_EXPAND && cnt == 4'd8)
      state_nxt = ST_DONE;
  end

  // Words 52/53 of iteration 8 have no target index and are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < AES192_NW; k++) w[k] <= '0;
      cnt <= '0;
    end else if (zeroize) begin
      for (int unsigned k = 0; k < AES192_NW; k++) w[k] <= '0;
      cnt <= '0;
    end else if (i_key_en) begin
      for (int unsigned k = 0; k < AES192_NK; k++) w[k] <= i_key[191 - 32*k -: 32];
      cnt <= 4'd1;
    end else if (state == ST_EXPAND) begin
      for (int unsigned k = AES192_NK; k < AES192_NW; k++)
        if (cnt == 4'(k / 6)) w[k] <= next_grp[191 - 32*(k % 6) -: 32];
      if (cnt != 4'd8) cnt <= cnt + 4'd1;
    end
  end

  assign o_key_ok = (state == ST_DONE);
  assign o_busy   = (state == ST_EXPAND);

  always_comb begin
    o_keyex = '0;
    for (int unsigned k = 0; k < AES192_NW; k++)
      o_keyex[1663 - 32*k -: 32] = w[k];
  end

endmodule
